// File: rtl/temp_seg7_display.sv
// temp_seg7_display: samples an I2C temperature reading at SAMPLE_PERIOD intervals and shows it on a 4-digit multiplexed 7-segment display
// Ports:
//   clk_200kHz      sole clock, rising edge
//   reset_n         asynchronous active-low reset
//   temp_data[7:0]  unsigned whole degrees C
//   seg[6:0]        {g,f,e,d,c,b,a}, active-low
//   an[3:0]         active-low digit enables, an[0] rightmost
//   dp              decimal point, active-low, always off
// Build option: define TEMP_FAHRENHEIT_EN to display degrees F (C*9/5+32) with unit letter F.
module temp_seg7_display #(
  parameter int SAMPLE_PERIOD = 20000,
  parameter int DIGIT_PERIOD  = 250
) (
  input  logic       clk_200kHz,
  input  logic       reset_n,
  input  logic [7:0] temp_data,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);
  localparam int SW = $clog2(SAMPLE_PERIOD + 1);
  localparam int RW = $clog2(DIGIT_PERIOD + 1);
  localparam logic [6:0] BLANK = 7'b1111111;
`ifdef TEMP_FAHRENHEIT_EN
  localparam logic [6:0] UNIT = 7'b0001110;
`else
  localparam logic [6:0] UNIT = 7'b1000110;
`endif

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
`ifdef TEMP_FAHRENHEIT_EN
    DIV,
`endif
    SHIFT,
    DONE
  } state_t;

  state_t        state;
  logic [SW-1:0] sample_cnt;
  logic [RW-1:0] refresh_cnt;
  logic [1:0]    sel;
  logic [3:0]    bit_cnt;
  logic [8:0]    work;
  logic [11:0]   bcd;
  logic [6:0]    dig [4];
  logic          tick;
  logic          wrap;

  assign tick = sample_cnt == SW'(SAMPLE_PERIOD - 1);
  assign wrap = refresh_cnt == RW'(DIGIT_PERIOD - 1);
  assign dp   = 1'b1;

  function automatic logic [6:0] hex7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return BLANK;
    endcase
  endfunction

  // One double-dabble step: add 3 to any BCD digit >= 5, then shift in the next binary bit.
  function automatic logic [11:0] dabble(input logic [11:0] b, input logic in);
    logic [3:0] h, t, o;
    h = b[11:8] >= 4'd5 ? b[11:8] + 4'd3 : b[11:8];
    t = b[7:4]  >= 4'd5 ? b[7:4]  + 4'd3 : b[7:4];
    o = b[3:0]  >= 4'd5 ? b[3:0]  + 4'd3 : b[3:0];
    return 12'({h, t, o, in});
  endfunction

`ifdef TEMP_FAHRENHEIT_EN
  // Restoring divide-by-5: the dividend register shifts out its MSB into the
  // remainder and shifts the quotient bit in at the bottom, so after 12 steps it holds the quotient.
  logic [11:0] dvd;
  logic [2:0]  rem;
  logic [3:0]  rsh;
  logic        qb;
  logic [11:0] quo;
  assign rsh = {rem, dvd[11]};
  assign qb  = rsh >= 4'd5;
  assign quo = {dvd[10:0], qb};
`endif

  always_ff @(posedge clk_200kHz or negedge reset_n)
    if (!reset_n) sample_cnt <= '0;
    else sample_cnt <= tick ? '0 : sample_cnt + SW'(1);

  // seg and an are registered from the same select so they always agree.
  always_ff @(posedge clk_200kHz or negedge reset_n)
    if (!reset_n) begin
      refresh_cnt <= '0;
      sel         <= '0;
      an          <= 4'b1111;
      seg         <= BLANK;
    end else begin
      refresh_cnt <= wrap ? '0 : refresh_cnt + RW'(1);
      sel         <= wrap ? sel + 2'd1 : sel;
      an          <= ~(4'b0001 << sel);
      seg         <= dig[sel];
    end

  always_ff @(posedge clk_200kHz or negedge reset_n)
    if (!reset_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      work    <= '0;
      bcd     <= '0;
      dig[0]  <= BLANK;
      dig[1]  <= BLANK;
      dig[2]  <= BLANK;
      dig[3]  <= BLANK;
`ifdef TEMP_FAHRENHEIT_EN
      dvd     <= '0;
      rem     <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (tick) state <= LOAD;
        LOAD: begin
`ifdef TEMP_FAHRENHEIT_EN
          dvd   <= 12'({temp_data, 3'b000}) + 12'(temp_data);
          rem   <= '0;
          state <= DIV;
`else
          work  <= {1'b0, temp_data};
          state <= SHIFT;
`endif
          bit_cnt <= '0;
          bcd     <= '0;
        end
`ifdef TEMP_FAHRENHEIT_EN
        DIV: begin
          dvd     <= quo;
          rem     <= qb ? 3'(rsh - 4'd5) : rsh[2:0];
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd11) begin
            work    <= 9'(quo + 12'd32);
            bit_cnt <= '0;
            state   <= SHIFT;
          end
        end
`endif
        SHIFT: begin
          bcd     <= dabble(bcd, work[8]);
          work    <= {work[7:0], 1'b0};
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd8) state <= DONE;
        end
        DONE: begin
          // Leading-zero blanking: tens is blank only when hundreds is blank too.
          dig[3] <= bcd[11:8] == 4'd0 ? BLANK : hex7(bcd[11:8]);
          dig[2] <= bcd[11:4] == 8'd0 ? BLANK : hex7(bcd[7:4]);
          dig[1] <= hex7(bcd[3:0]);
          dig[0] <= UNIT;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/temp_seg7_display.md
TEMP_SEG7_DISPLAY -- requirements
Module: temp_seg7_display

Interface
REQ-001 SHALL have ports: clk_200kHz  in  1  sole clock, all logic on rising edge.
REQ-002 SHALL have ports: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: temp_data  in  8  unsigned whole deg C from the I2C temperature master (0..255).
REQ-004 SHALL have ports: seg  out  7  {g,f,e,d,c,b,a}, active-low segment drives.
REQ-005 SHALL have ports: an  out  4  active-low digit enables; an[0] is the rightmost digit.
REQ-006 SHALL have ports: dp  out  1  decimal point, active-low, held 1 (off) at all times.
REQ-007 SHALL define parameters (name, default, meaning):
- SAMPLE_PERIOD, 20000: clk_200kHz cycles between samples (10 Hz).
- DIGIT_PERIOD, 250: cycles each digit stays enabled (800 Hz per digit, 200 Hz frame).

Function
REQ-008 SHALL run a sample counter 0..SAMPLE_PERIOD-1 that wraps; a start tick SHALL be issued in the cycle the counter equals SAMPLE_PERIOD-1.
REQ-009 SHALL implement the conversion FSM IDLE -> LOAD -> [DIV] -> SHIFT -> DONE -> IDLE. DIV exists only per REQ-020.
REQ-010 IDLE SHALL move to LOAD only on a start tick. A start tick outside IDLE SHALL be ignored.
REQ-011 LOAD (1 cycle) SHALL capture temp_data into a 9-bit working value, zero-extended.
- temp_data changes after LOAD SHALL NOT affect the conversion in progress.
REQ-012 SHALL convert the 9-bit value in SHIFT with shift-add-3 double-dabble, one bit per cycle, 9 cycles, into hundreds/tens/ones BCD.
REQ-013 DONE (1 cycle) SHALL update all four display digit registers together at its end, so the display never shows a partial result.
REQ-014 Latency from start tick to display update SHALL be 11 cycles (Celsius build).
REQ-015 Display content (left to right):
- digit3: hundreds, blanked if 0.
- digit2: tens, blanked if hundreds and tens are both 0.
- digit1: ones, always shown.
- digit0: unit letter, C = 7'b1000110, F = 7'b0001110.
REQ-016 Digit codes SHALL be standard active-low hex: 0 = 7'b1000000 ... 9 = 7'b0010000. Blank SHALL be 7'b1111111.
REQ-017 Scanning SHALL use a refresh counter 0..DIGIT_PERIOD-1.
- On each wrap, the active digit SHALL advance an[0] -> an[1] -> an[2] -> an[3] -> an[0].
- Exactly one an bit SHALL be low at a time.
- seg SHALL be registered together with an, so the two never mismatch.

Reset
REQ-018 While reset_n = 0 (asynchronous):
- seg = 7'b1111111, an = 4'b1111, dp = 1.
- FSM = IDLE; sample, refresh and bit counters = 0; all digit registers = blank.
REQ-019 Assertion mid-conversion SHALL abort it with no display update.
- After release, scanning SHALL start with an[0] within DIGIT_PERIOD cycles.
- The display SHALL stay blank until the first DONE, which follows the first start tick (cycle SAMPLE_PERIOD-1 after release).

Configuration
REQ-020 Macro TEMP_FAHRENHEIT_EN:
- Defined: LOAD SHALL compute C*9 (12 bits, max 2295). DIV SHALL then perform a 12-cycle restoring division by 5, floor, and add 32, giving 32..491 in the 9-bit working value.
- Defined: the unit letter SHALL be F, and latency SHALL be 23 cycles.
- Undefined: DIV SHALL be absent, the unit SHALL be C, and latency SHALL be 11 cycles.

Verification
REQ-021 C build: temp_data = 25 held, reset released -> after first DONE the scan shows an[3] blank, an[2] '2', an[1] '5', an[0] 'C'.
REQ-022 C build: temp_data = 0 -> blank, blank, '0', 'C'. temp_data = 255 -> '2', '5', '5', 'C'.
REQ-023 F build: temp_data = 25 -> blank, '7', '7', 'F'. 100 -> '2', '1', '2', 'F'. 255 -> '4', '9', '1', 'F'. DONE occurs 23 cycles after the start tick.
REQ-024 Change temp_data 25 -> 40 two cycles after LOAD -> the display shows 25 until the next sample period, then 40.
REQ-025 Pulse reset_n low during SHIFT -> seg = 7'b1111111 and an = 4'b1111 immediately (asynchronous). No digit shows data until the next DONE.
REQ-026 Over 1000 cycles, check every cycle: exactly one an bit is low, dp = 1, and each digit stays enabled exactly 250 cycles.
